// File: rtl/tcdm_bank_arb.sv
// Round-robin arbiter sharing one TCDM bank among NumIn initiators, with a fixed-latency response pipeline.
// Define TCDM_BANK_ARB_PERF_EN to build the saturating conflict/stall counters.
module tcdm_bank_arb #(
  parameter int unsigned NumIn        = 32'd4,
  parameter int unsigned ReqDataWidth = 32'd49,
  parameter int unsigned DataWidth    = 32'd32,
  parameter int unsigned RespLat      = 32'd1,
  parameter bit          WriteRespOn  = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumIn-1:0]                    req_i,
  input  logic [NumIn-1:0]                    wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]  wdata_i,
  output logic [NumIn-1:0]                    gnt_o,
  output logic [NumIn-1:0]                    vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]     rdata_o,
  output logic                                req_o,
  input  logic                                gnt_i,
  output logic [ReqDataWidth-1:0]             wdata_o,
  input  logic [DataWidth-1:0]                rdata_i,
  output logic [31:0]                         conf_cnt_o,
  output logic [31:0]                         stall_cnt_o
);

  localparam int unsigned IdxW = (NumIn > 32'd1) ? $clog2(NumIn) : 32'd1;

  logic [IdxW-1:0]  rr_r;
  logic [IdxW-1:0]  win_s;
  logic [IdxW-1:0]  rr_nxt_s;
  logic [NumIn-1:0] win_oh_s;
  logic             hs_s;
  logic             resp_en_s;
  logic             found_s;
  int unsigned      cand_s;
  // Each stage holds the responding initiator one-hot; all-zero means empty.
  logic [NumIn-1:0] resp_pipe_r [RespLat];

  assign req_o     = |req_i;
  assign hs_s      = req_o & gnt_i;
  assign resp_en_s = hs_s & (~wen_i[win_s] | WriteRespOn);
  assign rr_nxt_s  = (32'(win_s) == (NumIn - 32'd1)) ? {IdxW{1'b0}} : (win_s + {{(IdxW-1){1'b0}}, 1'b1});
  assign vld_o     = resp_pipe_r[RespLat-1];

  // Winner search: first requester at or above rr_r, wrapping to index 0.
  always_comb begin
    win_s   = rr_r;
    found_s = 1'b0;
    cand_s  = 32'd0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand_s = 32'(rr_r) + k;
      if (cand_s >= NumIn) begin
        cand_s = cand_s - NumIn;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[IdxW'(cand_s)]) begin
        win_s   = IdxW'(cand_s);
        found_s = 1'b1;
      end else begin
        win_s   = win_s;
      end
    end
  end

  // One-hot decode of the winner.
  always_comb begin
    win_oh_s = {NumIn{1'b0}};
    for (int unsigned i = 0; i < NumIn; i++) begin
      win_oh_s[i] = (32'(win_s) == i);
    end
  end

  // Grant and payload steering towards the bank.
  always_comb begin
    gnt_o   = {NumIn{1'b0}};
    wdata_o = {ReqDataWidth{1'b0}};
    if (hs_s) begin
      gnt_o = win_oh_s;
    end else begin
      gnt_o = {NumIn{1'b0}};
    end
    if (req_o) begin
      wdata_o = wdata_i[win_s];
    end else begin
      wdata_o = {ReqDataWidth{1'b0}};
    end
  end

  // Read data is broadcast; vld_o qualifies it.
  always_comb begin
    rdata_o = {NumIn{ {DataWidth{1'b0}} }};
    for (int unsigned i = 0; i < NumIn; i++) begin
      rdata_o[i] = rdata_i;
    end
  end

  // Round-robin pointer advances only on a completed handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_r <= {IdxW{1'b0}};
    end else if (hs_s) begin
      rr_r <= rr_nxt_s;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Response shift pipeline; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < RespLat; s++) begin
        resp_pipe_r[s] <= {NumIn{1'b0}};
      end
    end else begin
      resp_pipe_r[0] <= resp_en_s ? win_oh_s : {NumIn{1'b0}};
      for (int unsigned s = 1; s < RespLat; s++) begin
        resp_pipe_r[s] <= resp_pipe_r[s-1];
      end
    end
  end

`ifdef TCDM_BANK_ARB_PERF_EN
  logic [31:0] conf_cnt_r;
  logic [31:0] stall_cnt_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Saturating conflict and bank-stall counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conf_cnt_r  <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      conf_cnt_r  <= sat_inc(conf_cnt_r, ($countones(req_i) >= 32'd2));
      stall_cnt_r <= sat_inc(stall_cnt_r, req_o & ~gnt_i);
    end
  end

  assign conf_cnt_o  = conf_cnt_r;
  assign stall_cnt_o = stall_cnt_r;
`else
  assign conf_cnt_o  = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_tcdm_bank_arb.sv
// Bench for tcdm_bank_arb: directed vector table plus randomized traffic checked against a
// due-cycle reference model, on three instances (default, no write responses, latency 2).
module tb_tcdm_bank_arb;
  localparam int N = 4, RW = 49, DW = 32, MAXC = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [N-1:0]         req, wen;
  logic [N-1:0][RW-1:0] wdata;
  logic                 gnt;
  logic [DW-1:0]        rdata;

  logic [N-1:0] gnt_a, vld_a, gnt_b, vld_b, gnt_c, vld_c;
  logic [N-1:0][DW-1:0] rdo_a, rdo_b, rdo_c;
  logic req_a, req_b, req_c;
  logic [RW-1:0] wdo_a, wdo_b, wdo_c;
  logic [31:0] conf_a, stall_a, conf_b, stall_b, conf_c, stall_c;

  tcdm_bank_arb dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdo_a), .req_o(req_a), .gnt_i(gnt),
    .wdata_o(wdo_a), .rdata_i(rdata), .conf_cnt_o(conf_a), .stall_cnt_o(stall_a));

  tcdm_bank_arb #(.WriteRespOn(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdo_b), .req_o(req_b), .gnt_i(gnt),
    .wdata_o(wdo_b), .rdata_i(rdata), .conf_cnt_o(conf_b), .stall_cnt_o(stall_b));

  tcdm_bank_arb #(.RespLat(32'd2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_c), .vld_o(vld_c), .rdata_o(rdo_c), .req_o(req_c), .gnt_i(gnt),
    .wdata_o(wdo_c), .rdata_i(rdata), .conf_cnt_o(conf_c), .stall_cnt_o(stall_c));

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] wen;
    logic       gnt;
    logic [3:0] e_gnt;
    logic [3:0] e_va;
    logic [3:0] e_vb;
    logic [3:0] e_vc;
  } vec_t;

  vec_t tbl[22];
  vec_t nov;

  int n_vec = 0, n_err = 0;
  int cyc = 0, m_rr = 0;
  int unsigned m_conf = 0, m_stall = 0;
  bit chk_en = 1'b0;
  logic [3:0] due_a [MAXC];
  logic [3:0] due_b [MAXC];
  logic [3:0] due_c [MAXC];

  function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] w, logic g,
                              logic [3:0] eg, logic [3:0] ea, logic [3:0] eb, logic [3:0] ec);
    vec_t v;
    v.rst_n = r; v.req = q; v.wen = w; v.gnt = g;
    v.e_gnt = eg; v.e_va = ea; v.e_vb = eb; v.e_vc = ec;
    return v;
  endfunction

  function automatic int win_of(int rr, logic [3:0] q);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (rr + k) % 4;
      if (q[idx]) return idx;
    end
    return rr;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] w, input logic g);
    rst_n = r; req = q; wen = w; gnt = g;
    for (int i = 0; i < N; i++) wdata[i] = {17'($urandom), 32'($urandom)};
    rdata = $urandom;
  endtask

  task automatic cycle(input bit t_en, input vec_t v);
    int w;
    logic e_req;
    logic [3:0] e_gnt;
    logic [RW-1:0] e_wd;
    logic [31:0] e_conf, e_stall;
    @(negedge clk);
    e_req = |req;
    w     = win_of(m_rr, req);
    e_gnt = (e_req && gnt) ? 4'(1 << w) : 4'd0;
    e_wd  = e_req ? wdata[w] : {RW{1'b0}};
`ifdef TCDM_BANK_ARB_PERF_EN
    e_conf = m_conf; e_stall = m_stall;
`else
    e_conf = 32'd0; e_stall = 32'd0;
`endif
    if (chk_en) begin
      chk("req_o", req_a, e_req);
      chk("gnt_o", gnt_a, e_gnt);
      chk("wdata_o", wdo_a, e_wd);
      chk("vld_o", vld_a, due_a[cyc]);
      chk("gnt_o_nowr", gnt_b, e_gnt);
      chk("vld_o_nowr", vld_b, due_b[cyc]);
      chk("gnt_o_lat2", gnt_c, e_gnt);
      chk("vld_o_lat2", vld_c, due_c[cyc]);
      chk("conf_cnt_o", conf_a, e_conf);
      chk("stall_cnt_o", stall_a, e_stall);
      for (int i = 0; i < N; i++) chk("rdata_o", rdo_a[i], rdata);
    end
    if (t_en) begin
      chk("tbl_gnt", gnt_a, v.e_gnt);
      chk("tbl_vld", vld_a, v.e_va);
      chk("tbl_vld_nowr", vld_b, v.e_vb);
      chk("tbl_vld_lat2", vld_c, v.e_vc);
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_rr = 0; m_conf = 0; m_stall = 0;
      for (int k = cyc; k < cyc + 4; k++) begin
        due_a[k] = 4'd0; due_b[k] = 4'd0; due_c[k] = 4'd0;
      end
    end else begin
      if (e_req && gnt) begin
        due_a[cyc]   |= 4'(1 << w);
        if (!wen[w]) due_b[cyc] |= 4'(1 << w);
        due_c[cyc+1] |= 4'(1 << w);
        m_rr = (w + 1) % 4;
      end
      if ($countones(req) >= 2 && m_conf != 32'hFFFF_FFFF) m_conf++;
      if (e_req && !gnt && m_stall != 32'hFFFF_FFFF) m_stall++;
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      due_a[k] = 4'd0; due_b[k] = 4'd0; due_c[k] = 4'd0;
    end
    nov = mk(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    // Reset held with all requests pending, release, then a full rotation.
    tbl[0]  = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[3]  = mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0001, 4'b0001, 4'b0000);
    tbl[4]  = mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0010, 4'b0010, 4'b0001);
    tbl[5]  = mk(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b0100, 4'b0100, 4'b0010);
    // Bank stalls for three cycles, then grants.
    tbl[6]  = mk(1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b1000, 4'b1000, 4'b0100);
    tbl[7]  = mk(1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    tbl[8]  = mk(1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[9]  = mk(1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[10] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    // Move pointer to 3, then wrap-around with 1001.
    tbl[11] = mk(1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0001);
    tbl[12] = mk(1'b1, 4'b1001, 4'b0000, 1'b1, 4'b1000, 4'b0100, 4'b0100, 4'b0000);
    tbl[13] = mk(1'b1, 4'b1001, 4'b0000, 1'b1, 4'b0001, 4'b1000, 4'b1000, 4'b0100);
    // Store from 2 then load from 1.
    tbl[14] = mk(1'b1, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0001, 4'b0001, 4'b1000);
    tbl[15] = mk(1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0100, 4'b0000, 4'b0001);
    tbl[16] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 4'b0010, 4'b0100);
    tbl[17] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    // Handshake followed immediately by reset: latency-2 response must vanish.
    tbl[18] = mk(1'b1, 4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[19] = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    tbl[20] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[21] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    drive(1'b0, 4'b1111, 4'b0000, 1'b1);
    cycle(1'b0, nov);
    chk_en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst_n, tbl[i].req, tbl[i].wen, tbl[i].gnt);
      cycle(1'b1, tbl[i]);
    end
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(49) != 0), 4'($urandom), 4'($urandom), ($urandom_range(3) != 0));
      cycle(1'b0, nov);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
